// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: glyph table
// (active-high abcdefg, bit 6 = a), the blank pattern and sub-slot count.
package seg_scan_pkg;

    localparam int SUB_SLOTS  = 16;
    localparam int NUM_GLYPHS = 16;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Index = nibble value; entries 10..15 are the hex letters A b C d E F
    localparam logic [6:0] SEG_TABLE [NUM_GLYPHS] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

endpackage

// File: rtl/seg_scan_display_seg7_decode.sv
// Nibble to active-high segment decoder. Values 10..15 show hex letters only
// when hex_en is set, otherwise they decode to the blank pattern.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] value,
    input  logic       hex_en,
    output logic [6:0] seg_hi
);

    // Table lookup with hex gating; every input combination yields a defined pattern
    always_comb begin
        seg_hi = SEG_TABLE[value];
        if ((value >= 4'd10) && !hex_en) begin
            seg_hi = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment display scanner. A prescaler produces scan
// ticks; each digit owns 16 sub-slots, sub 0 is a blanking gap and subs
// 1..brightness are lit. Inputs are snapshotted once per frame.
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    hex_en,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_start
);

    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SUB_W = $clog2(SUB_SLOTS);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]    SLOT_LAST  = SW'(NUM_DIGITS - 1);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SUB_SLOTS - 1);

    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [PW-1:0]    presc;
    logic [SUB_W-1:0] sub;
    logic [SW-1:0]    slot;
    logic             tick;
    logic             snap_take;

    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap_hex;
    logic                    snap_lz;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic [3:0]            cur_val;
    logic [6:0]            dec_hi;
    logic                  window;
    logic                  lz_hit;
    logic                  dp_req;
    logic [6:0]            seg_next_hi;
    logic                  dp_next_hi;
    logic [NUM_DIGITS-1:0] dig_next_hi;

    assign tick = (presc == PRESC_LAST);
    // The tick whose state is slot 0 / sub 0 starts a frame; this is also the
    // very first tick after reset because reset parks the counters there.
    // That tick's own output is a blanking gap, so loading here never tears.
    assign snap_take = tick && (sub == '0) && (slot == '0);

    // Prescaler, sub-slot and slot counters
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            sub   <= '0;
            slot  <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                sub <= sub + 1'b1;
                if (sub == SUB_LAST) begin
                    slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                end
            end
        end
    end

    // Per-frame input snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_hex    <= 1'b0;
            snap_lz     <= 1'b0;
        end else if (snap_take) begin
            snap_digits <= digits_in;
            snap_dp     <= dp_in;
            snap_blank  <= blank_in;
            snap_hex    <= hex_en;
            snap_lz     <= lz_en;
        end
    end

    // Leading-zero mask: digit k is suppressed while digits 0..k are all zero; last digit never
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_run = zero_run && (snap_digits[4*i +: 4] == 4'd0);
            if (i < NUM_DIGITS - 1) begin
                lz_mask[i] = snap_lz && zero_run;
            end
        end
    end

    assign cur_val = snap_digits[{slot, 2'b00} +: 4];

    seg7_decode u_decode (
        .value  (cur_val),
        .hex_en (snap_hex),
        .seg_hi (dec_hi)
    );

    // Active-high view of what the current slot/sub should show
    always_comb begin
        window      = (sub != '0) && (sub <= brightness) && !snap_blank[slot];
        lz_hit      = lz_mask[slot];
        dp_req      = snap_dp[slot];
        seg_next_hi = (window && !lz_hit) ? dec_hi : SEG_BLANK;
        dp_next_hi  = window && dp_req;
        // A leading-zero digit stays enabled only to show its decimal point
        dig_next_hi = (window && (!lz_hit || dp_req)) ? (NUM_DIGITS'(1) << slot) : '0;
    end

    // Output registers: update once per tick, pin polarity applied here only
    always_ff @(posedge clk) begin
        if (reset) begin
            seg         <= SEG_OFF;
            dp          <= SEG_ACTIVE_LOW;
            dig_sel     <= DIG_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap_take;
            if (tick) begin
                seg     <= seg_next_hi ^ SEG_OFF;
                dp      <= dp_next_hi ^ SEG_ACTIVE_LOW;
                dig_sel <= dig_next_hi ^ DIG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (4 digits, tick every 2 clks, active-low pins).
module tb_seg_scan_display;

  localparam int ND = 4;
  localparam int TD = 2;
  localparam int FRAME_TICKS = 16 * ND;

  logic            clk = 1'b0;
  logic            reset;
  logic [4*ND-1:0] digits_in;
  logic [ND-1:0]   dp_in;
  logic [ND-1:0]   blank_in;
  logic            hex_en;
  logic            lz_en;
  logic [3:0]      brightness;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   dig_sel;
  logic            frame_start;

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  seg_scan_display #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .hex_en(hex_en), .lz_en(lz_en), .brightness(brightness),
    .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_start(frame_start)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [6:0] glyph(input logic [3:0] v, input logic hx);
    case (v)
      4'd0: return 7'b1111110;  4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;  4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;  4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;  4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;  4'd9: return 7'b1111011;
      4'd10: return hx ? 7'b1110111 : 7'b0;
      4'd11: return hx ? 7'b0011111 : 7'b0;
      4'd12: return hx ? 7'b1001110 : 7'b0;
      4'd13: return hx ? 7'b0111101 : 7'b0;
      4'd14: return hx ? 7'b1001111 : 7'b0;
      default: return hx ? 7'b1000111 : 7'b0;
    endcase
  endfunction

  // Returns pin-level {seg, dp, dig_sel} for digit k at sub-slot s
  function automatic logic [11:0] ref_pins(input int k, input int s, input int br,
      input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl,
      input logic hx, input logic lz);
    logic [6:0] sh;
    logic       dh, lit, lzb, allz;
    logic [3:0] onehot;
    lit  = (s >= 1) && (s <= br) && !bl[k];
    allz = 1'b1;
    for (int i = 0; i <= k; i++) if (((dg >> (4*i)) & 16'hF) != 0) allz = 1'b0;
    lzb  = lz && (k < ND-1) && allz;
    sh   = (lit && !lzb) ? glyph(4'((dg >> (4*k)) & 16'hF), hx) : 7'b0;
    dh   = lit && dpv[k];
    onehot = (lit && (!lzb || dpv[k])) ? 4'(1 << k) : 4'b0;
    return {~sh, ~dh, ~onehot};
  endfunction

  int         m_cyc;
  logic [11:0] m_pins;
  logic        m_fs;
  logic [15:0] m_dg;
  logic [3:0]  m_dp, m_bl;
  logic        m_hx, m_lz;

  // Counts clocks since reset release; tick n is the clock with cyc = n*TD + TD-1
  always @(posedge clk) begin
    if (reset) begin
      m_cyc = 0; m_pins = 12'hFFF; m_fs = 1'b0;
      m_dg = '0; m_dp = '0; m_bl = '0; m_hx = 1'b0; m_lz = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (m_cyc % TD == TD-1) begin
        int n;
        n = m_cyc / TD;
        if (n % FRAME_TICKS == 0) begin
          m_dg = digits_in; m_dp = dp_in; m_bl = blank_in; m_hx = hex_en; m_lz = lz_en;
          m_fs = 1'b1;
        end
        m_pins = ref_pins((n / 16) % ND, n % 16, int'(brightness), m_dg, m_dp, m_bl, m_hx, m_lz);
      end
      m_cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      exp_q.push_back({m_pins, m_fs});
      n_vec++;
      if ({seg, dp, dig_sel, frame_start} !== exp_q[0]) begin
        n_bad++;
        $display("FAIL model t=%0t seg/dp/dig/fs got %b %b %b %b want %b %b %b %b", $time,
                 seg, dp, dig_sel, frame_start, exp_q[0][12:6], exp_q[0][5], exp_q[0][4:1], exp_q[0][0]);
      end
      void'(exp_q.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl,
                            input logic hx, input logic lz, input logic [3:0] br);
    digits_in = dg; dp_in = dpv; blank_in = bl; hex_en = hx; lz_en = lz; brightness = br;
  endtask

  // Reset, release, then stop on the negedge just after tick n's outputs register
  task automatic restart_to_tick(input int n);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (TD*n + TD) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [15:0] dg;
    logic [3:0]  dpv, bl;
    logic        hx, lz;
    logic [3:0]  br;
    int          slot, sub;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_dig;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [15:0] dg, logic [3:0] dpv, logic [3:0] bl,
      logic hx, logic lz, logic [3:0] br, int sl, int sb, logic [6:0] es, logic ed, logic [3:0] eg);
    vec_t v;
    v.name = nm; v.dg = dg; v.dpv = dpv; v.bl = bl; v.hx = hx; v.lz = lz; v.br = br;
    v.slot = sl; v.sub = sb; v.e_seg = es; v.e_dp = ed; v.e_dig = eg;
    return v;
  endfunction

  initial begin
    int lit_cnt;
    reset = 1'b1;
    set_inputs(16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd15);
    repeat (3) @(negedge clk);
    chk("reset_state", {seg, dp, dig_sel, frame_start}, {7'h7F, 1'b1, 4'hF, 1'b0});
    chk_en = 1'b1;

    // ---- table-driven vectors ----
    vecs.push_back(mk("d1_slot0",      16'h4321, 4'h0, 4'h0, 0, 0, 15, 0, 1,  7'h4F, 1, 4'b1110));
    vecs.push_back(mk("gap_sub0",      16'h4321, 4'h0, 4'h0, 0, 0, 15, 0, 0,  7'h7F, 1, 4'b1111));
    vecs.push_back(mk("d4_slot3",      16'h4321, 4'h0, 4'h0, 0, 0, 15, 3, 15, 7'h4C, 1, 4'b0111));
    vecs.push_back(mk("lz_digit0",     16'h0050, 4'h0, 4'h0, 0, 1, 15, 0, 5,  7'h7F, 1, 4'b1111));
    vecs.push_back(mk("lz_digit1_5",   16'h0050, 4'h0, 4'h0, 0, 1, 15, 1, 5,  7'h24, 1, 4'b1101));
    vecs.push_back(mk("lz_digit2_0",   16'h0050, 4'h0, 4'h0, 0, 1, 15, 2, 5,  7'h01, 1, 4'b1011));
    vecs.push_back(mk("lz_all0_d2",    16'h0000, 4'h0, 4'h0, 0, 1, 15, 2, 7,  7'h7F, 1, 4'b1111));
    vecs.push_back(mk("lz_all0_last",  16'h0000, 4'h0, 4'h0, 0, 1, 15, 3, 7,  7'h01, 1, 4'b0111));
    vecs.push_back(mk("hex_b_on",      16'h000B, 4'h0, 4'h0, 1, 0, 15, 0, 1,  7'h60, 1, 4'b1110));
    vecs.push_back(mk("hex_b_off",     16'h000B, 4'h0, 4'h0, 0, 0, 15, 0, 1,  7'h7F, 1, 4'b1110));
    vecs.push_back(mk("bright3_sub3",  16'h4321, 4'h0, 4'h0, 0, 0, 3,  1, 3,  7'h12, 1, 4'b1101));
    vecs.push_back(mk("bright3_sub4",  16'h4321, 4'h0, 4'h0, 0, 0, 3,  1, 4,  7'h7F, 1, 4'b1111));
    vecs.push_back(mk("bright0",       16'h4321, 4'h0, 4'h0, 0, 0, 0,  0, 1,  7'h7F, 1, 4'b1111));
    vecs.push_back(mk("blank_dp",      16'h4321, 4'h1, 4'h1, 0, 0, 15, 0, 1,  7'h7F, 1, 4'b1111));
    vecs.push_back(mk("lz_keeps_dp",   16'h0050, 4'h1, 4'h0, 0, 1, 15, 0, 1,  7'h7F, 0, 4'b1110));
    vecs.push_back(mk("dp_digit2",     16'h4321, 4'h4, 4'h0, 0, 0, 15, 2, 2,  7'h06, 0, 4'b1011));

    foreach (vecs[i]) begin
      set_inputs(vecs[i].dg, vecs[i].dpv, vecs[i].bl, vecs[i].hx, vecs[i].lz, vecs[i].br);
      restart_to_tick(16 * vecs[i].slot + vecs[i].sub);
      chk(vecs[i].name, {seg, dp, dig_sel}, {vecs[i].e_seg, vecs[i].e_dp, vecs[i].e_dig});
    end

    // ---- snapshot holds for the whole frame ----
    set_inputs(16'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 4'd15);
    restart_to_tick(17);
    digits_in = 16'h8888;
    repeat (TD*16) @(negedge clk);
    chk("no_tear_slot2", {seg, dig_sel}, {7'h06, 4'b1011});
    repeat (TD*(FRAME_TICKS - 33)) @(negedge clk);
    chk("new_frame_start", frame_start, 1'b1);
    repeat (TD) @(negedge clk);
    chk("new_frame_slot0", {seg, dig_sel}, {7'h00, 4'b1110});

    // ---- lit time per slot ----
    set_inputs(16'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 4'd3);
    restart_to_tick(0);
    lit_cnt = 0;
    for (int c = 0; c < TD*FRAME_TICKS; c++) begin
      @(negedge clk);
      if (dig_sel !== 4'hF) lit_cnt++;
    end
    chk("bright3_lit_clks", lit_cnt, ND * 3 * TD);
    brightness = 4'd0;
    lit_cnt = 0;
    for (int c = 0; c < TD*FRAME_TICKS; c++) begin
      @(negedge clk);
      if (dig_sel !== 4'hF) lit_cnt++;
    end
    chk("bright0_lit_clks", lit_cnt, 0);

    // ---- reset pulse mid-slot 2 ----
    set_inputs(16'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 4'd15);
    restart_to_tick(37);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_off", {seg, dp, dig_sel, frame_start}, {7'h7F, 1'b1, 4'hF, 1'b0});
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_no_fs_yet", frame_start, 1'b0);
    @(negedge clk);
    chk("midreset_fs", {frame_start, dig_sel}, {1'b1, 4'hF});
    repeat (TD) @(negedge clk);
    chk("midreset_slot0", {seg, dig_sel}, {7'h4F, 4'b1110});

    // ---- randomized stimulus against the model ----
    for (int r = 0; r < 40; r++) begin
      set_inputs(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) < 3 ? $urandom : 0),
                 1'($urandom), 1'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) digits_in = digits_in & 16'hF00F;
      repeat ($urandom_range(1, 150)) begin
        @(negedge clk);
        if ($urandom_range(0, 40) == 0) brightness = 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
